// File: rtl/game_pkg.sv
// Shared types and defaults for the piano-tiles round sequencer.
package game_pkg;

    localparam int FRAME_W = 8;
    localparam int HOLD_W  = 4;

    localparam int DEF_BEAT_CYCLES = 50000000;
    localparam int DEF_SONG_LEN    = 52;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Two-flop synchroniser plus rising-edge detect for a raw button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic [2:0] sh;

    // Chain resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh <= 3'b111;
        else        sh <= {sh[1:0], btn};
    end

    assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/game_sequencer.sv
// Round controller: buttons, beat divider, frame advance, hit/miss strobes.
// Define SONG_LOOP_EN to wrap the song to frame 0 instead of ending in DONE.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BEAT_CYCLES     = DEF_BEAT_CYCLES,
    parameter int SONG_LEN        = DEF_SONG_LEN,
    parameter int COUNTDOWN_BEATS = 3
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic [HOLD_W-1:0]  hold_length,
    input  logic               correct_key_pressed,
    output logic [FRAME_W-1:0] game_frame,
    output logic               beat,
    output logic               frame_adv,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [HOLD_W-1:0]  hold_remaining,
    output logic [2:0]         state
);

    localparam int DIV_W = $clog2(BEAT_CYCLES);
    localparam int CD_W  = $clog2(COUNTDOWN_BEATS + 1);

    localparam logic [DIV_W-1:0]   DIV_TOP  = DIV_W'(BEAT_CYCLES - 1);
    localparam logic [CD_W-1:0]    CD_LOAD  = CD_W'(COUNTDOWN_BEATS);
    localparam logic [FRAME_W-1:0] LAST_FRM = FRAME_W'(SONG_LEN - 1);

    logic start_req;
    logic pause_req;

    btn_edge u_start (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .btn   (start_btn),
        .pulse (start_req)
    );

    btn_edge u_pause (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .btn   (pause_btn),
        .pulse (pause_req)
    );

    state_t            st;
    state_t            resume;
    logic [DIV_W-1:0]  div;
    logic [CD_W-1:0]   cd_cnt;
    logic              latch;
    logic              tick;
    logic              hit;
    logic [HOLD_W-1:0] hold_min1;

    assign tick      = (div == DIV_TOP);
    assign hit       = latch | correct_key_pressed;
    assign hold_min1 = (hold_length == '0) ? HOLD_W'(1) : hold_length;
    assign state     = st;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            st             <= S_IDLE;
            resume         <= S_COUNTDOWN;
            div            <= '0;
            cd_cnt         <= '0;
            latch          <= 1'b0;
            game_frame     <= '0;
            hold_remaining <= '0;
            beat           <= 1'b0;
            frame_adv      <= 1'b0;
            hit_pulse      <= 1'b0;
            miss_pulse     <= 1'b0;
        end else begin
            beat       <= 1'b0;
            frame_adv  <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            unique case (st)
                S_IDLE, S_DONE: begin
                    div <= '0;
                    if (start_req) begin
                        st         <= S_COUNTDOWN;
                        cd_cnt     <= CD_LOAD;
                        game_frame <= '0;
                    end
                end
                S_COUNTDOWN: begin
                    if (pause_req) begin
                        st     <= S_PAUSE;
                        resume <= S_COUNTDOWN;
                    end else if (tick) begin
                        div    <= '0;
                        beat   <= 1'b1;
                        cd_cnt <= cd_cnt - CD_W'(1);
                        if (cd_cnt == CD_W'(1)) begin
                            st             <= S_PLAY;
                            hold_remaining <= hold_min1;
                            latch          <= 1'b0;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_PLAY: begin
                    // hold_length now reflects the frame just entered.
                    if (frame_adv) hold_remaining <= hold_min1;
                    if (correct_key_pressed) latch <= 1'b1;
                    if (pause_req) begin
                        st     <= S_PAUSE;
                        resume <= S_PLAY;
                    end else if (tick) begin
                        div            <= '0;
                        beat           <= 1'b1;
                        hit_pulse      <= hit;
                        miss_pulse     <= ~hit;
                        latch          <= 1'b0;
                        hold_remaining <= hold_remaining - HOLD_W'(1);
                        if (hold_remaining <= HOLD_W'(1)) begin
                            if (game_frame == LAST_FRM) begin
`ifdef SONG_LOOP_EN
                                game_frame <= '0;
                                frame_adv  <= 1'b1;
`else
                                st <= S_DONE;
`endif
                            end else begin
                                game_frame <= game_frame + FRAME_W'(1);
                                frame_adv  <= 1'b1;
                            end
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (pause_req) st <= resume;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a hit/miss scoreboard.
module tb_game_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       start_btn;
    logic       pause_btn;
    logic [3:0] hold_length;
    logic       correct_key_pressed;
    logic [7:0] game_frame;
    logic       beat;
    logic       frame_adv;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [3:0] hold_remaining;
    logic [2:0] state;

    logic [3:0] hold_tab [0:2];
    logic [1:0] exp_q [$];
    logic [1:0] e;
    int total = 0;
    int bad   = 0;

    game_sequencer #(
        .BEAT_CYCLES     (4),
        .SONG_LEN        (3),
        .COUNTDOWN_BEATS (2)
    ) dut (
        .CLOCK_50            (CLOCK_50),
        .reset_n             (reset_n),
        .start_btn           (start_btn),
        .pause_btn           (pause_btn),
        .hold_length         (hold_length),
        .correct_key_pressed (correct_key_pressed),
        .game_frame          (game_frame),
        .beat                (beat),
        .frame_adv           (frame_adv),
        .hit_pulse           (hit_pulse),
        .miss_pulse          (miss_pulse),
        .hold_remaining      (hold_remaining),
        .state               (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Engine model: per-frame note hold lengths.
    always_comb begin
        hold_length = 4'd0;
        if (game_frame < 8'd3) hold_length = hold_tab[game_frame[1:0]];
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        chk(tag, 32'({beat, frame_adv, hit_pulse, miss_pulse}), 0);
    endtask

    always @(negedge CLOCK_50) begin
        if (reset_n && (hit_pulse || miss_pulse)) begin
            total++;
            assert (!(hit_pulse && miss_pulse)) else begin
                bad++;
                $error("FAIL both_strobes: got hit=1 miss=1 want one");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL sb_empty: got strobe %b want none",
                       {hit_pulse, miss_pulse});
            end else begin
                e = exp_q.pop_front();
                assert ({hit_pulse, miss_pulse} === e) else begin
                    bad++;
                    $error("FAIL sb_strobe: got %b want %b",
                           {hit_pulse, miss_pulse}, e);
                end
            end
        end
    end

    initial begin
        reset_n             = 1'b0;
        start_btn           = 1'b1;
        pause_btn           = 1'b0;
        correct_key_pressed = 1'b0;
        hold_tab[0] = 4'd1;
        hold_tab[1] = 4'd2;
        hold_tab[2] = 4'd1;

        // 1: reset with start held
        step(3);
        reset_n = 1'b1;
        chk("rst_state", 32'(state), 0);
        chk("rst_frame", 32'(game_frame), 0);
        chk("rst_hold", 32'(hold_remaining), 0);
        quiet("rst_pulses");
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("held_start_state", 32'(state), 0);
            quiet("held_start_pulses");
        end
        start_btn = 1'b0;
        step(3);

        // 2: start, countdown, play
        start_btn = 1'b1;
        step(2);
        chk("start_lat2", 32'(state), 0);
        step(1);
        chk("start_lat3", 32'(state), 1);
        chk("start_frame", 32'(game_frame), 0);
        start_btn = 1'b0;
        step(3);
        chk("cd_nobeat", 32'(beat), 0);
        step(1);
        chk("cd_beat1", 32'(beat), 1);
        chk("cd_state1", 32'(state), 1);
        step(4);
        chk("cd_beat2", 32'(beat), 1);
        chk("play_state", 32'(state), 2);
        chk("play_hold0", 32'(hold_remaining), 1);

        // 3: hit on beat 1, miss on beat 2
        step(2);
        correct_key_pressed = 1'b1;
        exp_q.push_back(2'b10);
        step(1);
        correct_key_pressed = 1'b0;
        step(1);
        chk("f0_adv", 32'(frame_adv), 1);
        chk("f0_frame", 32'(game_frame), 1);
        chk("f0_hold", 32'(hold_remaining), 0);
        step(1);
        chk("f1_reload", 32'(hold_remaining), 2);
        chk("f1_adv_once", 32'(frame_adv), 0);
        exp_q.push_back(2'b01);
        step(3);
        chk("f1_beat1", 32'(beat), 1);
        chk("f1_hold1", 32'(hold_remaining), 1);
        chk("f1_noadv", 32'(frame_adv), 0);

        // 4: pause with divider at 2
        pause_btn = 1'b1;
        step(2);
        chk("pause_lat2", 32'(state), 2);
        step(1);
        chk("pause_state", 32'(state), 3);
        pause_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            correct_key_pressed = (i >= 5 && i < 8);
            step(1);
            chk("pause_silent", 32'({beat, state}), 3);
        end
        correct_key_pressed = 1'b0;
        pause_btn = 1'b1;
        exp_q.push_back(2'b01);
        step(2);
        chk("resume_lat2", 32'(state), 3);
        step(1);
        chk("resume_state", 32'(state), 2);
        pause_btn = 1'b0;
        step(1);
        chk("resume_nobeat", 32'(beat), 0);
        step(1);
        chk("resume_beat", 32'(beat), 1);
        chk("f1_adv", 32'(frame_adv), 1);
        chk("f2_frame", 32'(game_frame), 2);
        step(1);
        chk("f2_hold", 32'(hold_remaining), 1);
        exp_q.push_back(2'b01);
        step(3);
        chk("f2_beat", 32'(beat), 1);
`ifdef SONG_LOOP_EN
        chk("loop_frame", 32'(game_frame), 0);
        chk("loop_adv", 32'(frame_adv), 1);
        chk("loop_state", 32'(state), 2);
        step(1);
        chk("loop_reload", 32'(hold_remaining), 1);
`else
        chk("done_state", 32'(state), 4);
        chk("done_frame", 32'(game_frame), 2);
        chk("done_noadv", 32'(frame_adv), 0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            quiet("done_quiet");
            chk("done_hold", 32'({state, game_frame}), 32'({3'd4, 8'd2}));
        end
`endif

        // 6b: asynchronous reset mid-beat
        @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_frame", 32'(game_frame), 0);
        chk("async_rst_hold", 32'(hold_remaining), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);
        step(2);
        reset_n = 1'b1;
        step(3);

        // 5: hold_length 0 on frame 1
        hold_tab[1] = 4'd0;
        start_btn = 1'b1;
        step(3);
        chk("r2_state", 32'(state), 1);
        start_btn = 1'b0;
        step(8);
        chk("r2_play", 32'(state), 2);
        exp_q.push_back(2'b01);
        step(4);
        chk("r2_adv0", 32'(frame_adv), 1);
        chk("r2_frame1", 32'(game_frame), 1);
        step(1);
        chk("r2_hold_min1", 32'(hold_remaining), 1);
        exp_q.push_back(2'b01);
        step(3);
        chk("r2_adv1", 32'(frame_adv), 1);
        chk("r2_frame2", 32'(game_frame), 2);
        exp_q.push_back(2'b01);
        step(4);
        chk("r2_last_beat", 32'(beat), 1);
`ifdef SONG_LOOP_EN
        chk("r2_wrap", 32'({state, game_frame}), 32'({3'd2, 8'd0}));
        start_btn = 1'b1;
        step(3);
        chk("r2_start_ignored", 32'(state), 2);
`else
        chk("r2_done", 32'({state, game_frame}), 32'({3'd4, 8'd2}));
        start_btn = 1'b1;
        step(3);
        chk("r2_restart", 32'({state, game_frame}), 32'({3'd1, 8'd0}));
`endif
        start_btn = 1'b0;
        chk("sb_final", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
